asm_layer_sequencer: RTL

//  Initiator side of the ASM accumulator interface. It streams one binary layer through a single ASM lane.
//  - Reads feature/weight/BN memories and drives data_pix, data_weight, data_bn, calculate_en, asm_send and asm_reception.
//  - Samples the ASM's data_out bit for each output neuron.
//  - Packs the bits into words and writes them to the next-layer feature SRAM.

---
 rtl/asm_layer_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/asm_layer_sequencer.sv
// -----------------------------------------------------------------------------
// asm_layer_sequencer
//
// Initiator side of the ASM accumulator interface. Streams one binary layer
// through a single ASM lane: reads the feature, weight and BN memories, feeds
// one product per cycle to the ASM, samples the thresholded result bit of each
// output neuron and packs those bits, LSB first, into words for the next-layer
// feature SRAM.
//
// Ports
//   clk, rst            clock (posedge) and synchronous active-high reset
//   start               launch one layer (accepted only in IDLE)
//   busy, done          busy from the cycle after accept until done; done is
//                       a one-cycle pulse after the last word is written
//   pix_rd_en/addr/rdata   feature memory, i = input index, 1-cycle latency
//   wt_rd_en/addr/rdata    weight memory, k*IN_LEN+i, 1-cycle latency
//   bn_rd_en/addr/rdata    BN threshold memory, k = neuron, 1-cycle latency
//   calculate_en        ASM enable (RUN and DRAIN only)
//   data_pix            product feature code, 2'b10 pad when no product
//   data_weight         product weight bit, 0 when no product
//   data_bn             threshold of the neuron being sent, 0 otherwise
//   asm_send            last product of a neuron
//   asm_reception       ASM loads data_bn (coincides with asm_send)
//   asm_data_out        ASM result bit, sampled the cycle after a send
//   out_wr_en/addr/wdata   output SRAM write port
// -----------------------------------------------------------------------------
module asm_layer_sequencer #(
    parameter int IN_LEN     = 64,
    parameter int OUT_NUM    = 32,
    parameter int BN_WIDTH   = 16,
    parameter int WORD_WIDTH = 16,
    localparam int WORDS     = (OUT_NUM + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int AW_I      = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
    localparam int AW_W      = (IN_LEN * OUT_NUM > 1) ? $clog2(IN_LEN * OUT_NUM) : 1,
    localparam int AW_K      = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1,
    localparam int AW_O      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pix_rd_en,
    output logic [AW_I-1:0]       pix_addr,
    input  logic [1:0]            pix_rdata,
    output logic                  wt_rd_en,
    output logic [AW_W-1:0]       wt_addr,
    input  logic                  wt_rdata,
    output logic                  bn_rd_en,
    output logic [AW_K-1:0]       bn_addr,
    input  logic [BN_WIDTH-1:0]   bn_rdata,
    output logic                  calculate_en,
    output logic [1:0]            data_pix,
    output logic                  data_weight,
    output logic [BN_WIDTH-1:0]   data_bn,
    output logic                  asm_send,
    output logic                  asm_reception,
    input  logic                  asm_data_out,
    output logic                  out_wr_en,
    output logic [AW_O-1:0]       out_addr,
    output logic [WORD_WIDTH-1:0] out_wdata
);

    localparam int AW_B = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [AW_I-1:0] I_LAST = AW_I'(IN_LEN - 1);
    localparam logic [AW_K-1:0] K_LAST = AW_K'(OUT_NUM - 1);
    localparam logic [AW_B-1:0] B_LAST = AW_B'(WORD_WIDTH - 1);
    localparam logic [1:0]      PAD    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;

    // Read-side counters: i fastest, then k; j mirrors k*IN_LEN+i.
    logic [AW_I-1:0] i_cnt;
    logic [AW_K-1:0] k_cnt;
    logic [AW_W-1:0] j_cnt;

    // Read data returns one cycle after issue; these flags travel with it.
    logic prod_valid;
    logic prod_last;

    // Capture/pack side.
    logic                  cap_pending;
    logic [AW_K-1:0]       cap_k;
    logic [AW_B-1:0]       bit_idx;
    logic [WORD_WIDTH-1:0] pack;
    logic [WORD_WIDTH-1:0] pack_filled;

    logic                  wr_q;
    logic [AW_O-1:0]       addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;

    logic read_fire;
    logic last_in_neuron;
    logic last_read;
    logic send;
    logic final_cap;
    logic word_full;

    assign read_fire      = (state == S_RUN);
    assign last_in_neuron = read_fire && (i_cnt == I_LAST);
    assign last_read      = last_in_neuron && (k_cnt == K_LAST);
    assign send           = prod_valid && prod_last;
    assign final_cap      = cap_pending && (cap_k == K_LAST);
    // The last neuron flushes a partial word; unused MSBs stay 0 from pack.
    assign word_full      = (bit_idx == B_LAST) || (cap_k == K_LAST);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_RUN;
            S_RUN:   if (last_read) state_nxt = S_DRAIN;
            S_DRAIN: if (final_cap) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pack_filled          = pack;
        pack_filled[bit_idx] = asm_data_out;
    end

    // Interface outputs.
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FLUSH);
    assign calculate_en  = (state == S_RUN) || (state == S_DRAIN);

    assign pix_rd_en     = read_fire;
    assign pix_addr      = i_cnt;
    assign wt_rd_en      = read_fire;
    assign wt_addr       = j_cnt;
    assign bn_rd_en      = last_in_neuron;
    assign bn_addr       = k_cnt;

    // Products come straight from the read data; idle slots present a pad
    // code that the ASM accumulates as zero.
    assign data_pix      = prod_valid ? pix_rdata : PAD;
    assign data_weight   = prod_valid & wt_rdata;
    assign data_bn       = send ? bn_rdata : '0;
    assign asm_send      = send;
    assign asm_reception = send;

    assign out_wr_en     = wr_q;
    assign out_addr      = addr_q;
    assign out_wdata     = wdata_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            i_cnt       <= '0;
            k_cnt       <= '0;
            j_cnt       <= '0;
            prod_valid  <= 1'b0;
            prod_last   <= 1'b0;
            cap_pending <= 1'b0;
            cap_k       <= '0;
            bit_idx     <= '0;
            pack        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state       <= state_nxt;
            prod_valid  <= read_fire;
            prod_last   <= last_in_neuron;
            cap_pending <= send;
            wr_q        <= 1'b0;

            if (read_fire) begin
                if (i_cnt == I_LAST) begin
                    i_cnt <= '0;
                    k_cnt <= last_read ? '0 : k_cnt + 1'b1;
                end else begin
                    i_cnt <= i_cnt + 1'b1;
                end
                j_cnt <= last_read ? '0 : j_cnt + 1'b1;
            end

            // The ASM result for neuron cap_k is valid one cycle after its send.
            if (cap_pending) begin
                cap_k <= (cap_k == K_LAST) ? '0 : cap_k + 1'b1;
                if (word_full) begin
                    wr_q    <= 1'b1;
                    wdata_q <= pack_filled;
                    pack    <= '0;
                    bit_idx <= '0;
                end else begin
                    pack    <= pack_filled;
                    bit_idx <= bit_idx + 1'b1;
                end
            end

            // Address moves on after each write and is rewound by the final one.
            if (wr_q) begin
                addr_q <= (state == S_FLUSH) ? '0 : addr_q + 1'b1;
            end
        end
    end

endmodule
